commit_sequencer: RTL and testbench
===================================

Name: commit_sequencer

Overview:
- Merges the result streams of the execution branches (misc, MAC, memory and so on) into one in-order writeback stream.
- Each branch result carries a 9-bit commit_id. This block releases results strictly in commit_id order, using one ready/valid handshake per lane.
- It sits between the branch outputs and the register-file/commit stage.
- A watchdog flags a missing commit_id; a duplicate commit_id is also flagged.

Parameters:
- data_width, 16, sample width; results are 2*data_width.
- n_blocks, 256, number of blocks; block id width is $clog2(n_blocks).
- n_lanes, 4, number of branch input lanes (2..8).
- timeout, 255, cycles with no eligible lane before err_timeout sets.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  global advance; when low, no state changes and no handshakes complete
- clear  in  1  single-cycle pulse: expected id to 0, output drained, errors cleared
- in_valid  in  n_lanes  per-lane valid
- in_ready  out  n_lanes  per-lane ready
- in_block  in  n_lanes*$clog2(n_blocks)  lane block ids, lane k at slice k
- in_dest  in  n_lanes*4  lane destination codes
- in_result  in  n_lanes*2*data_width  lane results
- in_commit_id  in  n_lanes*9  lane commit ids
- in_commit_flag  in  n_lanes  lane commit flags
- out_valid  out  1  output registered valid
- out_ready  in  1  downstream ready
- block_out  out  $clog2(n_blocks)  granted block id
- dest_out  out  4  granted dest
- result_out  out  2*data_width  granted result
- commit_id_out  out  9  granted commit id
- commit_flag_out  out  1  granted commit flag
- expected_id  out  9  next commit id to release
- err_timeout  out  1  sticky; watchdog expired
- err_dup  out  1  sticky; two valid lanes presented the same expected id

Behaviour:
- Reset or clear: out_valid=0, expected_id=0, watchdog=0, err_timeout=0, err_dup=0. Data outputs are don't-care while out_valid=0.
- clear takes priority over all other events in the same cycle; no lane handshake completes in the clear cycle.
- Eligibility: lane k is eligible when in_valid[k] && in_commit_id[k]==expected_id.
- Grant: the lowest-index eligible lane.
- If more than one lane is eligible, the lowest index wins and err_dup sets.
- space = ~out_valid | out_ready.
- in_ready[k] = enable & space & grant[k] & ~clear; at most one bit is high.
- Non-granted lanes hold their data (standard ready/valid).
- Take (any in_ready & in_valid): the output registers load the granted lane's fields; out_valid<=1; expected_id<=expected_id+1, wrapping 511 to 0.
- Latency is 1 cycle from input handshake to out_valid.
- Take with out_ready high and out_valid high gives back-to-back throughput of 1 result per cycle.
- No take, out_valid & out_ready: out_valid<=0.
- enable low freezes everything, including the watchdog.
- Watchdog:
  - Counts cycles where enable, no eligible lane and at least one in_valid is high.
  - Resets to 0 on any take, or when all in_valid are low.
  - Reaching timeout sets err_timeout and saturates the counter.
  - err_timeout does not block operation.
- Wrap-around: commit_id comparison is exact 9-bit equality; there is no ordering logic beyond equality.
- Reset mid-transfer: pending output is discarded; upstream lanes must also be reset.

Decomposition:
- Shared package holds:
  - COMMIT_ID_W=9 and DEST_W=4.
  - A commit-result struct {block, dest, result, commit_id, commit_flag}, shared with the branch modules.
- One sub-module, prio_grant: a combinational lowest-index one-hot grant plus a multi-hit flag, parameterised by n_lanes.
- Everything else stays in commit_sequencer.

Test Plan:
- Reset release; lane2 offers id 0 and lane0 offers id 1 in the same cycle -> lane2 is taken in cycle 0, lane0 is taken in cycle 1; commit_id_out is 0 then 1; expected_id=2.
- out_ready held low for 3 cycles with out_valid=1 -> all in_ready stay 0 and the output stays stable; on release, the next id is accepted in the same cycle as the drain.
- expected_id=511; lane1 offers id 511, then lane3 offers id 0 -> both are released in order; expected_id wraps to 1.
- lane0 and lane1 both offer id 5 while expected_id=5 -> lane0 is granted; err_dup=1 and stays set until clear.
- timeout=4; lane0 holds id 9 while expected_id=8 -> err_timeout sets after 4 cycles; clear pulse -> expected_id=0, err_timeout=0, out_valid=0.
- enable low for 2 cycles mid-stream with valid inputs -> no handshakes, watchdog does not advance; the stream resumes in the same order.

Source files
------------

// File: rtl/commit_sequencer_pkg.sv
// Shared types and widths for the commit path: commit ids, destination codes
// and the branch result record exchanged between branch modules and the sequencer.
package commit_sequencer_pkg;

  localparam int COMMIT_ID_W = 9;
  localparam int DEST_W      = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int BLOCK_W_DEF = 8;

  typedef struct packed {
    logic [BLOCK_W_DEF-1:0]  block;
    logic [DEST_W-1:0]       dest;
    logic [2*DATA_W_DEF-1:0] result;
    logic [COMMIT_ID_W-1:0]  commit_id;
    logic                    commit_flag;
  } commit_result_t;

endpackage

// File: rtl/commit_sequencer_prio_grant.sv
// Combinational lowest-index one-hot grant over the request vector, plus
// flags for "any request" and "more than one request".
module prio_grant
  import commit_sequencer_pkg::*;
#(
  parameter int n_lanes = 4
) (
  input  logic [n_lanes-1:0] req,
  output logic [n_lanes-1:0] grant,
  output logic               any_hit,
  output logic               multi_hit
);

  localparam logic [n_lanes-1:0] ONE = {{(n_lanes-1){1'b0}}, 1'b1};

  // isolating the lowest set bit gives the one-hot winner
  assign grant     = req & ~(req - ONE);
  assign any_hit   = |req;
  assign multi_hit = |(req & ~grant);

endmodule

// File: rtl/commit_sequencer.sv
// Merges per-lane branch results into a single writeback stream released
// strictly in commit_id order, with missing-id watchdog and duplicate-id flags.
module commit_sequencer
  import commit_sequencer_pkg::*;
#(
  parameter int data_width = 16,
  parameter int n_blocks   = 256,
  parameter int n_lanes    = 4,
  parameter int timeout    = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  clear,
  input  logic [n_lanes-1:0]                    in_valid,
  output logic [n_lanes-1:0]                    in_ready,
  input  logic [n_lanes*$clog2(n_blocks)-1:0]   in_block,
  input  logic [n_lanes*DEST_W-1:0]             in_dest,
  input  logic [n_lanes*2*data_width-1:0]       in_result,
  input  logic [n_lanes*COMMIT_ID_W-1:0]        in_commit_id,
  input  logic [n_lanes-1:0]                    in_commit_flag,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [$clog2(n_blocks)-1:0]           block_out,
  output logic [DEST_W-1:0]                     dest_out,
  output logic [2*data_width-1:0]               result_out,
  output logic [COMMIT_ID_W-1:0]                commit_id_out,
  output logic                                  commit_flag_out,
  output logic [COMMIT_ID_W-1:0]                expected_id,
  output logic                                  err_timeout,
  output logic                                  err_dup
);

  localparam int BLOCK_W = $clog2(n_blocks);
  localparam int RES_W   = 2 * data_width;
  localparam int WD_W    = $clog2(timeout + 1);
  localparam logic [WD_W-1:0] TIMEOUT_V  = WD_W'(timeout);
  localparam logic [WD_W-1:0] TIMEOUT_M1 = WD_W'(timeout - 1);
  localparam logic [WD_W-1:0] WD_ONE     = WD_W'(1);
  localparam logic [COMMIT_ID_W-1:0] ID_ONE = COMMIT_ID_W'(1);

  logic [n_lanes-1:0]     elig_s;
  logic [n_lanes-1:0]     grant_s;
  logic [n_lanes-1:0]     in_ready_s;
  logic                   any_elig_s;
  logic                   multi_elig_s;
  logic                   space_s;
  logic                   take_s;
  logic                   any_valid_s;
  logic [BLOCK_W-1:0]     sel_block_s;
  logic [DEST_W-1:0]      sel_dest_s;
  logic [RES_W-1:0]       sel_result_s;
  logic [COMMIT_ID_W-1:0] sel_id_s;
  logic                   sel_flag_s;

  logic                   out_valid_r;
  logic [BLOCK_W-1:0]     block_r;
  logic [DEST_W-1:0]      dest_r;
  logic [RES_W-1:0]       result_r;
  logic [COMMIT_ID_W-1:0] commit_id_r;
  logic                   commit_flag_r;
  logic [COMMIT_ID_W-1:0] expected_id_r;
  logic [WD_W-1:0]        wd_r;
  logic                   err_timeout_r;
  logic                   err_dup_r;

  // a lane is eligible when it presents exactly the next id to release
  always_comb begin
    elig_s = '0;
    for (int k = 0; k < n_lanes; k++) begin
      elig_s[k] = in_valid[k] & (in_commit_id[k*COMMIT_ID_W +: COMMIT_ID_W] == expected_id_r);
    end
  end

  prio_grant #(.n_lanes(n_lanes)) u_prio_grant (
    .req       (elig_s),
    .grant     (grant_s),
    .any_hit   (any_elig_s),
    .multi_hit (multi_elig_s)
  );

  assign any_valid_s = |in_valid;
  assign space_s     = ~out_valid_r | out_ready;
  assign in_ready_s  = {n_lanes{enable & space_s & ~clear}} & grant_s;
  assign take_s      = |(in_ready_s & in_valid);

  // AND-OR select of the granted lane's fields; grant is one-hot or zero
  always_comb begin
    sel_block_s  = '0;
    sel_dest_s   = '0;
    sel_result_s = '0;
    sel_id_s     = '0;
    sel_flag_s   = 1'b0;
    for (int k = 0; k < n_lanes; k++) begin
      sel_block_s  = sel_block_s  | (in_block[k*BLOCK_W +: BLOCK_W] & {BLOCK_W{grant_s[k]}});
      sel_dest_s   = sel_dest_s   | (in_dest[k*DEST_W +: DEST_W] & {DEST_W{grant_s[k]}});
      sel_result_s = sel_result_s | (in_result[k*RES_W +: RES_W] & {RES_W{grant_s[k]}});
      sel_id_s     = sel_id_s     | (in_commit_id[k*COMMIT_ID_W +: COMMIT_ID_W] & {COMMIT_ID_W{grant_s[k]}});
      sel_flag_s   = sel_flag_s   | (in_commit_flag[k] & grant_s[k]);
    end
  end

  // output stage, release pointer, watchdog and sticky error flags
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_valid_r   <= 1'b0;
      block_r       <= '0;
      dest_r        <= '0;
      result_r      <= '0;
      commit_id_r   <= '0;
      commit_flag_r <= 1'b0;
      expected_id_r <= '0;
      wd_r          <= '0;
      err_timeout_r <= 1'b0;
      err_dup_r     <= 1'b0;
    end else if (enable) begin
      if (take_s) begin
        out_valid_r   <= 1'b1;
        block_r       <= sel_block_s;
        dest_r        <= sel_dest_s;
        result_r      <= sel_result_s;
        commit_id_r   <= sel_id_s;
        commit_flag_r <= sel_flag_s;
        expected_id_r <= expected_id_r + ID_ONE;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (multi_elig_s) begin
        err_dup_r <= 1'b1;
      end
      // an eligible lane stalled only by back-pressure holds the count
      if (take_s || !any_valid_s) begin
        wd_r <= '0;
      end else if (!any_elig_s && (wd_r != TIMEOUT_V)) begin
        wd_r <= wd_r + WD_ONE;
        if (wd_r == TIMEOUT_M1) begin
          err_timeout_r <= 1'b1;
        end
      end
    end
  end

  assign in_ready        = in_ready_s;
  assign out_valid       = out_valid_r;
  assign block_out       = block_r;
  assign dest_out        = dest_r;
  assign result_out      = result_r;
  assign commit_id_out   = commit_id_r;
  assign commit_flag_out = commit_flag_r;
  assign expected_id     = expected_id_r;
  assign err_timeout     = err_timeout_r;
  assign err_dup         = err_dup_r;

endmodule

// File: tb/tb_commit_sequencer.sv
// Randomized and directed bench for commit_sequencer, checked against a
// cycle-level reference model of the in-order release rules.
module tb_commit_sequencer;

  localparam int NL = 4;
  localparam int DW = 16;
  localparam int NB = 256;
  localparam int TO = 4;
  localparam int BW = 8;
  localparam int RW = 2 * DW;

  logic clk = 1'b0;
  logic reset, enable, clear, out_ready;
  logic [NL-1:0]    in_valid, in_ready, in_commit_flag;
  logic [NL*BW-1:0] in_block;
  logic [NL*4-1:0]  in_dest;
  logic [NL*RW-1:0] in_result;
  logic [NL*9-1:0]  in_commit_id;
  logic             out_valid, commit_flag_out, err_timeout, err_dup;
  logic [BW-1:0]    block_out;
  logic [3:0]       dest_out;
  logic [RW-1:0]    result_out;
  logic [8:0]       commit_id_out, expected_id;

  commit_sequencer #(.data_width(DW), .n_blocks(NB), .n_lanes(NL), .timeout(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_dest(in_dest),
    .in_result(in_result), .in_commit_id(in_commit_id), .in_commit_flag(in_commit_flag),
    .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out), .dest_out(dest_out),
    .result_out(result_out), .commit_id_out(commit_id_out), .commit_flag_out(commit_flag_out),
    .expected_id(expected_id), .err_timeout(err_timeout), .err_dup(err_dup)
  );

  always #5 clk = ~clk;

  // lane sources
  logic          s_v[NL];
  logic [8:0]    s_id[NL];
  logic [BW-1:0] s_blk[NL];
  logic [3:0]    s_dst[NL];
  logic [RW-1:0] s_res[NL];
  logic          s_flg[NL];

  always_comb begin
    in_valid = '0; in_block = '0; in_dest = '0; in_result = '0;
    in_commit_id = '0; in_commit_flag = '0;
    for (int k = 0; k < NL; k++) begin
      in_valid[k]             = s_v[k];
      in_block[k*BW +: BW]    = s_blk[k];
      in_dest[k*4 +: 4]       = s_dst[k];
      in_result[k*RW +: RW]   = s_res[k];
      in_commit_id[k*9 +: 9]  = s_id[k];
      in_commit_flag[k]       = s_flg[k];
    end
  end

  // reference model state
  int          m_exp;
  bit          m_ov;
  logic [53:0] m_pay;
  int          m_wd;
  bit          m_eto, m_edup;
  int          last_take;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exp = 0; m_ov = 1'b0; m_pay = '0; m_wd = 0; m_eto = 1'b0; m_edup = 1'b0;
  endtask

  task automatic offer(input int k, input int id);
    s_v[k]   = 1'b1;
    s_id[k]  = 9'(id);
    s_blk[k] = BW'($urandom);
    s_dst[k] = 4'($urandom);
    s_res[k] = RW'($urandom);
    s_flg[k] = 1'($urandom);
  endtask

  task automatic idle_all();
    for (int k = 0; k < NL; k++) s_v[k] = 1'b0;
  endtask

  // one clock: compare at negedge, then advance the model after the edge
  task automatic step();
    int g, cnt;
    bit space, take, anyv;
    logic [NL-1:0] exp_rdy;
    @(negedge clk);
    check_val("out_valid", out_valid, m_ov);
    check_val("expected_id", expected_id, 64'(m_exp));
    check_val("err_timeout", err_timeout, m_eto);
    check_val("err_dup", err_dup, m_edup);
    if (m_ov) check_val("payload", {block_out, dest_out, result_out, commit_id_out, commit_flag_out}, m_pay);
    g = -1; cnt = 0; anyv = 1'b0;
    for (int k = 0; k < NL; k++) begin
      if (s_v[k]) anyv = 1'b1;
      if (s_v[k] && (int'(s_id[k]) == m_exp)) begin
        cnt++;
        if (g < 0) g = k;
      end
    end
    space   = !m_ov || out_ready;
    take    = !clear && enable && space && (cnt > 0);
    exp_rdy = take ? (NL'(1) << g) : '0;
    check_val("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    #1;
    last_take = take ? g : -1;
    if (clear) begin
      model_reset();
    end else if (enable) begin
      if (take) begin
        m_pay = {s_blk[g], s_dst[g], s_res[g], s_id[g], s_flg[g]};
        m_ov  = 1'b1;
        m_exp = (m_exp + 1) % 512;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (cnt > 1) m_edup = 1'b1;
      if (take || !anyv) m_wd = 0;
      else if (cnt == 0) begin
        if (m_wd < TO) m_wd++;
        if (m_wd == TO) m_eto = 1'b1;
      end
    end
    if (take) s_v[g] = 1'b0;
  endtask

  task automatic feed_until(input int target);
    for (int i = 0; i < 600 && m_exp != target; i++) begin
      offer(0, m_exp);
      step();
    end
    idle_all();
    check_val("feed_reach", 64'(m_exp), 64'(target));
  endtask

  initial begin
    for (int k = 0; k < NL; k++) begin
      s_v[k] = 1'b0; s_id[k] = '0; s_blk[k] = '0; s_dst[k] = '0; s_res[k] = '0; s_flg[k] = 1'b0;
    end
    reset = 1'b1; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // lane2 id0 and lane0 id1 together: released in id order
    offer(2, 0); offer(0, 1);
    step(); check_val("t1_first_lane", 64'(last_take), 64'(2));
    step(); check_val("t1_second_lane", 64'(last_take), 64'(0));
    check_val("t1_cid", commit_id_out, 64'(1));
    check_val("t1_exp", expected_id, 64'(2));
    step();

    // back-pressure holds the output and blocks all lanes
    out_ready = 1'b0;
    offer(0, 2); step();
    offer(1, 3);
    repeat (3) step();
    check_val("t2_cid_held", commit_id_out, 64'(2));
    out_ready = 1'b1;
    step(); check_val("t2_drain_take", 64'(last_take), 64'(1));
    step();

    // id wrap 511 -> 0
    feed_until(511);
    offer(1, 511); offer(3, 0);
    step(); check_val("t3_lane511", 64'(last_take), 64'(1));
    step(); check_val("t3_lane0", 64'(last_take), 64'(3));
    check_val("t3_exp_wrap", expected_id, 64'(1));
    step();

    // duplicate id: lowest lane wins, err_dup sticky until clear
    clear = 1'b1; step(); clear = 1'b0;
    feed_until(5);
    offer(0, 5); offer(1, 5);
    step(); check_val("t4_dup_grant", 64'(last_take), 64'(0));
    check_val("t4_err_dup", err_dup, 64'(1));
    repeat (3) step();
    check_val("t4_err_dup_sticky", err_dup, 64'(1));
    clear = 1'b1; step(); clear = 1'b0;
    idle_all();
    check_val("t4_dup_cleared", err_dup, 64'(0));

    // missing id 8 while id 9 waits -> watchdog
    feed_until(8);
    offer(0, 9);
    repeat (3) step();
    check_val("t5_no_timeout_yet", err_timeout, 64'(0));
    step();
    check_val("t5_timeout", err_timeout, 64'(1));
    step();
    clear = 1'b1; step(); clear = 1'b0;
    idle_all();
    check_val("t5_clr_exp", expected_id, 64'(0));
    check_val("t5_clr_to", err_timeout, 64'(0));
    check_val("t5_clr_ov", out_valid, 64'(0));

    // enable low freezes handshakes
    offer(0, 0); offer(1, 1);
    enable = 1'b0;
    step(); step();
    check_val("t6_frozen_exp", expected_id, 64'(0));
    enable = 1'b1;
    step(); check_val("t6_resume0", 64'(last_take), 64'(0));
    step(); check_val("t6_resume1", 64'(last_take), 64'(1));
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NL; k++) begin
        if (!s_v[k] && ($urandom_range(0, 1) == 1)) offer(k, (m_exp + int'($urandom_range(0, 3))) % 512);
      end
      if (m_wd >= TO + 2) offer(int'($urandom_range(0, NL - 1)), m_exp);
      step();
    end
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
